// File: rtl/load_ext_unit.sv
// ---------------------------------------------------------------------------
// load_ext_unit
//
// Load-side data path at the M stage. Accepts one load at a time, sends a
// word-aligned read to a variable-latency data memory, stalls the pipeline
// until the response returns, then extracts the addressed byte, halfword or
// word and sign- or zero-extends it. Misaligned loads raise ld_adel and never
// reach memory (when CHECK_ALIGN=1).
//
// Parameters
//   CHECK_ALIGN  1: misaligned lw/lh/lhu raise ld_adel and issue no read
//                0: no check; lw ignores addr[1:0], halfwords use addr[1]
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   ld_req     in   load present in M stage this cycle
//   ld_op      in   [2:0] 0 lw, 1 lbu, 2 lb, 3 lhu, 4 lh, 5-7 as lw
//   ld_addr    in   [31:0] byte address of the load
//   ld_flush   in   discard the current or pending load
//   ld_busy    out  stall request to the pipeline (combinational)
//   dm_req     out  read request level to data memory (registered)
//   dm_addr    out  [31:0] word-aligned read address (registered)
//   dm_rvalid  in   one-cycle response strobe from memory
//   dm_rdata   in   [31:0] read word, valid with dm_rvalid
//   ld_valid   out  one-cycle pulse: ld_data holds a completed result
//   ld_data    out  [31:0] extended load result (registered)
//   ld_adel    out  one-cycle pulse: misaligned load detected
// ---------------------------------------------------------------------------
module load_ext_unit #(
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_req,
    input  logic [2:0]  ld_op,
    input  logic [31:0] ld_addr,
    input  logic        ld_flush,
    output logic        ld_busy,
    output logic        dm_req,
    output logic [31:0] dm_addr,
    input  logic        dm_rvalid,
    input  logic [31:0] dm_rdata,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic        ld_adel
);

    // ABORT covers a read that has been issued but whose result is no
    // longer wanted; its response must still be absorbed before the next
    // read can go out, otherwise it would be taken as the new load's data.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ABORT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  lo_q, lo_d;
    logic        dm_req_q, dm_req_d;
    logic [31:0] dm_addr_q, dm_addr_d;
    logic        valid_q, valid_d;
    logic [31:0] data_q, data_d;
    logic        adel_q, adel_d;

    logic misaligned;
    logic accept;

    // Select the addressed byte/halfword of the returned word and extend it.
    // Ops 5-7 fall through to the full-word case together with lw.
    function automatic logic [31:0] extend(input logic [2:0]  op,
                                           input logic [1:0]  lo,
                                           input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lo)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = lo[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            3'd1:    res = {24'd0, b};
            3'd2:    res = {{24{b[7]}}, b};
            3'd3:    res = {16'd0, h};
            3'd4:    res = {{16{h[15]}}, h};
            default: res = rdata;
        endcase
        return res;
    endfunction

    // Alignment check on the incoming request. Byte loads can never be
    // misaligned; with the check disabled nothing is flagged.
    always_comb begin
        misaligned = 1'b0;
        if (CHECK_ALIGN) begin
            case (ld_op)
                3'd1, 3'd2: misaligned = 1'b0;
                3'd3, 3'd4: misaligned = ld_addr[0];
                default:    misaligned = |ld_addr[1:0];
            endcase
        end
    end

    assign accept = (state_q == IDLE) && ld_req && !ld_flush && !misaligned;

    // Stall: the accepting cycle and all of WAIT stall. In ABORT a waiting
    // load must be held off until the stale response has drained.
    always_comb begin
        case (state_q)
            IDLE:    ld_busy = accept;
            WAIT:    ld_busy = 1'b1;
            ABORT:   ld_busy = ld_req;
            default: ld_busy = 1'b0;
        endcase
    end

    // Next-state and next-output computation. Pulses default low; the
    // result register and the read address hold unless explicitly updated.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        lo_d      = lo_q;
        dm_addr_d = dm_addr_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        adel_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ld_req && !ld_flush) begin
                    if (misaligned) begin
                        adel_d = 1'b1;
                    end else begin
                        state_d   = WAIT;
                        op_d      = ld_op;
                        lo_d      = ld_addr[1:0];
                        dm_addr_d = {ld_addr[31:2], 2'b00};
                    end
                end
            end
            WAIT: begin
                if (ld_flush) begin
                    state_d = dm_rvalid ? IDLE : ABORT;
                end else if (dm_rvalid) begin
                    data_d  = extend(op_q, lo_q, dm_rdata);
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            ABORT: begin
                if (dm_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        dm_req_d = (state_d == WAIT);
    end

    // State and registered outputs, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= 3'd0;
            lo_q      <= 2'd0;
            dm_req_q  <= 1'b0;
            dm_addr_q <= 32'd0;
            valid_q   <= 1'b0;
            data_q    <= 32'd0;
            adel_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            lo_q      <= lo_d;
            dm_req_q  <= dm_req_d;
            dm_addr_q <= dm_addr_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            adel_q    <= adel_d;
        end
    end

    assign dm_req   = dm_req_q;
    assign dm_addr  = dm_addr_q;
    assign ld_valid = valid_q;
    assign ld_data  = data_q;
    assign ld_adel  = adel_q;

endmodule

// File: tb/tb_load_ext_unit.sv
// ---------------------------------------------------------------------------
// tb_load_ext_unit
//
// Drives two copies of load_ext_unit (alignment check on and off) from the
// same inputs. A transaction-level model tracks, per copy, whether a read is
// outstanding and whether its result is still wanted; every cycle all
// outputs of both copies are compared against it. Directed scenarios add
// literal expectations on the results.
// ---------------------------------------------------------------------------
module tb_load_ext_unit;

    logic        clk;
    logic        reset;
    logic        ldReq;
    logic [2:0]  ldOp;
    logic [31:0] ldAddr;
    logic        ldFlush;
    logic        dmRvalid;
    logic [31:0] dmRdata;

    logic [1:0]  busyW, reqW, validW, adelW;
    logic [31:0] addrW [2];
    logic [31:0] dataW [2];

    // Copy A checks alignment, copy B does not.
    load_ext_unit #(.CHECK_ALIGN(1'b1)) dutA (
        .clk(clk), .reset(reset), .ld_req(ldReq), .ld_op(ldOp),
        .ld_addr(ldAddr), .ld_flush(ldFlush), .ld_busy(busyW[0]),
        .dm_req(reqW[0]), .dm_addr(addrW[0]), .dm_rvalid(dmRvalid),
        .dm_rdata(dmRdata), .ld_valid(validW[0]), .ld_data(dataW[0]),
        .ld_adel(adelW[0])
    );

    load_ext_unit #(.CHECK_ALIGN(1'b0)) dutB (
        .clk(clk), .reset(reset), .ld_req(ldReq), .ld_op(ldOp),
        .ld_addr(ldAddr), .ld_flush(ldFlush), .ld_busy(busyW[1]),
        .dm_req(reqW[1]), .dm_addr(addrW[1]), .dm_rvalid(dmRvalid),
        .dm_rdata(dmRdata), .ld_valid(validW[1]), .ld_data(dataW[1]),
        .ld_adel(adelW[1])
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors = 0;
    int miscompares = 0;
    bit checkOn = 1'b0;

    int          validCntA, adelCntA, busyCntA, adelCntB;
    bit          reqSeenA;
    logic [31:0] lastDataA, lastDataB;
    logic [31:0] validDataA [$];

    // Model state per copy: a read is outstanding, and its result is wanted.
    bit          mOut   [2];
    bit          mWant  [2];
    logic [2:0]  mOp    [2];
    logic [1:0]  mLo    [2];
    logic [31:0] mAddr  [2];
    logic [31:0] mData  [2];
    bit          mValid [2];
    bit          mAdel  [2];

    logic [2:0]  sweepOp   [4] = '{3'd1, 3'd3, 3'd4, 3'd0};
    logic [31:0] sweepAddr [4] = '{32'h3001, 32'h3002, 32'h3000, 32'h3000};
    int          sweepLat  [4] = '{1, 2, 3, 1};
    logic [31:0] sweepExp  [4] = '{32'h0000_00F0, 32'h0000_8765,
                                   32'hFFFF_F0A1, 32'h8765_F0A1};

    // Access size in bytes; copy 0 checks that the address is a multiple.
    function automatic bit modelMisaligned(input int cfg, input logic [2:0] op,
                                           input logic [31:0] addr);
        int size;
        if (op == 3'd1 || op == 3'd2)      size = 1;
        else if (op == 3'd3 || op == 3'd4) size = 2;
        else                               size = 4;
        return (cfg == 0) && ((addr % size) != 0);
    endfunction

    // Shift the wanted piece down and extend it arithmetically.
    function automatic logic [31:0] modelExtend(input logic [2:0] op,
                                                input logic [1:0] lo,
                                                input logic [31:0] w);
        int unsigned b, h, sh;
        sh = 8 * lo;
        b  = (w >> sh) & 32'hFF;
        sh = 16 * lo[1];
        h  = (w >> sh) & 32'hFFFF;
        case (op)
            3'd1:    return b;
            3'd2:    return b - ((b & 32'h80) << 1);
            3'd3:    return h;
            3'd4:    return h - ((h & 32'h8000) << 1);
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] expBusy(input int i);
        if (mOut[i]) return mWant[i] ? 32'd1 : 32'(ldReq);
        return 32'(ldReq && !ldFlush && !modelMisaligned(i, ldOp, ldAddr));
    endfunction

    // Model update on each rising edge from the inputs held since negedge.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                mOut[i]   <= 1'b0;
                mWant[i]  <= 1'b0;
                mValid[i] <= 1'b0;
                mAdel[i]  <= 1'b0;
                mData[i]  <= 32'd0;
                mAddr[i]  <= 32'd0;
            end else begin
                mValid[i] <= 1'b0;
                mAdel[i]  <= 1'b0;
                if (mOut[i]) begin
                    if (dmRvalid) begin
                        mOut[i]  <= 1'b0;
                        mWant[i] <= 1'b0;
                        if (mWant[i] && !ldFlush) begin
                            mValid[i] <= 1'b1;
                            mData[i]  <= modelExtend(mOp[i], mLo[i], dmRdata);
                        end
                    end else if (ldFlush) begin
                        mWant[i] <= 1'b0;
                    end
                end else if (ldReq && !ldFlush) begin
                    if (modelMisaligned(i, ldOp, ldAddr)) begin
                        mAdel[i] <= 1'b1;
                    end else begin
                        mOut[i]  <= 1'b1;
                        mWant[i] <= 1'b1;
                        mOp[i]   <= ldOp;
                        mLo[i]   <= ldAddr[1:0];
                        mAddr[i] <= ldAddr - (ldAddr % 4);
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got,
                               input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle compare, one cycle-fraction before the rising edge.
    initial begin
        string tag;
        wait (checkOn);
        forever begin
            @(negedge clk);
            #4;
            for (int i = 0; i < 2; i++) begin
                tag = (i == 0) ? "A" : "B";
                checkOutput({tag, " ld_busy"},  32'(busyW[i]),  expBusy(i));
                checkOutput({tag, " dm_req"},   32'(reqW[i]),   32'(mOut[i] && mWant[i]));
                checkOutput({tag, " dm_addr"},  addrW[i],       mAddr[i]);
                checkOutput({tag, " ld_valid"}, 32'(validW[i]), 32'(mValid[i]));
                checkOutput({tag, " ld_data"},  dataW[i],       mData[i]);
                checkOutput({tag, " ld_adel"},  32'(adelW[i]),  32'(mAdel[i]));
            end
            if (validW[0]) begin
                validCntA++;
                lastDataA = dataW[0];
                validDataA.push_back(dataW[0]);
            end
            if (validW[1]) lastDataB = dataW[1];
            if (adelW[0]) adelCntA++;
            if (adelW[1]) adelCntB++;
            if (reqW[0]) reqSeenA = 1'b1;
            if (busyW[0]) busyCntA++;
        end
    end

    task automatic resetLogs();
        validCntA = 0;
        adelCntA  = 0;
        adelCntB  = 0;
        busyCntA  = 0;
        reqSeenA  = 1'b0;
        lastDataA = 32'hDEAD_0000;
        lastDataB = 32'hDEAD_0000;
        validDataA.delete();
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // One load: request for a cycle, response after 'lat' WAIT cycles,
    // optional flush in WAIT cycle 'flushAt' (0 = none).
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] addr,
                                 input int lat, input logic [31:0] rdata,
                                 input int flushAt);
        @(negedge clk);
        ldReq  = 1'b1;
        ldOp   = op;
        ldAddr = addr;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            ldReq    = 1'b0;
            ldFlush  = (k == flushAt);
            dmRvalid = (k == lat);
            dmRdata  = (k == lat) ? rdata : $urandom;
        end
        @(negedge clk);
        ldReq    = 1'b0;
        ldFlush  = 1'b0;
        dmRvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset    = 1'b1;
        ldReq    = 1'b0;
        ldOp     = 3'd0;
        ldAddr   = 32'd0;
        ldFlush  = 1'b0;
        dmRvalid = 1'b0;
        dmRdata  = 32'd0;
        resetLogs();
        @(posedge clk);
        checkOn = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        settle();
        checkOutput("reset dm_req",   32'(reqW[0]),   32'd0);
        checkOutput("reset dm_addr",  addrW[0],       32'd0);
        checkOutput("reset ld_data",  dataW[0],       32'd0);
        checkOutput("reset ld_valid", 32'(validW[0]), 32'd0);

        // lb with one-cycle memory latency
        resetLogs();
        applyStimulus(3'd2, 32'h0000_1003, 1, 32'h80AA_BBCC, 0);
        settle();
        checkOutput("lb dm_addr",     addrW[0],        32'h0000_1000);
        checkOutput("lb data",        lastDataA,       32'hFFFF_FF80);
        checkOutput("lb valid count", 32'(validCntA),  32'd1);
        checkOutput("lb busy cycles", 32'(busyCntA),   32'd2);

        // extension sweep on one read word
        for (int s = 0; s < 4; s++) begin
            resetLogs();
            applyStimulus(sweepOp[s], sweepAddr[s], sweepLat[s], 32'h8765_F0A1, 0);
            settle();
            checkOutput("sweep data", lastDataA, sweepExp[s]);
        end

        // misaligned lw: A flags it, B reads the whole word
        resetLogs();
        applyStimulus(3'd0, 32'h0000_2002, 1, 32'h1234_5678, 0);
        settle();
        checkOutput("adel count A",      32'(adelCntA),  32'd1);
        checkOutput("adel dm_req A",     32'(reqSeenA),  32'd0);
        checkOutput("adel busy A",       32'(busyCntA),  32'd0);
        checkOutput("adel data kept A",  dataW[0],       32'h8765_F0A1);
        checkOutput("noalign count B",   32'(adelCntB),  32'd0);
        checkOutput("noalign addr B",    addrW[1],       32'h0000_2000);
        checkOutput("noalign data B",    lastDataB,      32'h1234_5678);

        // flush in 2nd WAIT cycle of a 4-cycle read, new load during ABORT
        resetLogs();
        @(negedge clk);
        ldReq = 1'b1; ldOp = 3'd4; ldAddr = 32'h0000_4000;
        @(negedge clk);
        ldReq = 1'b0;
        @(negedge clk);
        ldFlush = 1'b1;
        @(negedge clk);
        ldFlush = 1'b0;
        ldReq = 1'b1; ldOp = 3'd1; ldAddr = 32'h0000_5001;
        #4;
        checkOutput("abort dm_req", 32'(reqW[0]),  32'd0);
        checkOutput("abort busy",   32'(busyW[0]), 32'd1);
        @(negedge clk);
        dmRvalid = 1'b1; dmRdata = 32'hDEAD_BEEF;
        @(negedge clk);
        dmRvalid = 1'b0;
        #4;
        checkOutput("abort no valid", 32'(validCntA), 32'd0);
        @(negedge clk);
        ldReq = 1'b0;
        dmRvalid = 1'b1; dmRdata = 32'h1122_3344;
        @(negedge clk);
        dmRvalid = 1'b0;
        settle();
        checkOutput("after abort count", 32'(validCntA), 32'd1);
        checkOutput("after abort data",  lastDataA,      32'h0000_0033);

        // flush coincident with the response, then an immediate new load
        resetLogs();
        applyStimulus(3'd0, 32'h0000_6000, 2, 32'hCAFE_F00D, 2);
        checkOutput("flush+rvalid valid", 32'(validCntA), 32'd0);
        resetLogs();
        applyStimulus(3'd1, 32'h0000_6000, 1, 32'h0000_00AB, 0);
        settle();
        checkOutput("post-flush data", lastDataA,     32'h0000_00AB);
        checkOutput("post-flush busy", 32'(busyCntA), 32'd2);

        // reset while waiting; the late response must be ignored
        resetLogs();
        @(negedge clk);
        ldReq = 1'b1; ldOp = 3'd0; ldAddr = 32'h0000_7004;
        @(negedge clk);
        ldReq = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; dmRvalid = 1'b1; dmRdata = 32'h5555_AAAA;
        #4;
        checkOutput("reset-wait dm_req",  32'(reqW[0]), 32'd0);
        checkOutput("reset-wait dm_addr", addrW[0],     32'd0);
        @(negedge clk);
        dmRvalid = 1'b0;
        settle();
        checkOutput("reset-wait valid", 32'(validCntA), 32'd0);
        checkOutput("reset-wait data",  dataW[0],       32'd0);

        // back-to-back: second load issued in the first one's ld_valid cycle
        resetLogs();
        @(negedge clk);
        ldReq = 1'b1; ldOp = 3'd1; ldAddr = 32'h0000_8000;
        @(negedge clk);
        ldReq = 1'b0; dmRvalid = 1'b1; dmRdata = 32'h0000_00FF;
        @(negedge clk);
        dmRvalid = 1'b0;
        ldReq = 1'b1; ldOp = 3'd2; ldAddr = 32'h0000_8002;
        #4;
        checkOutput("b2b first valid", 32'(validW[0]), 32'd1);
        checkOutput("b2b accept busy", 32'(busyW[0]),  32'd1);
        @(negedge clk);
        ldReq = 1'b0; dmRvalid = 1'b1; dmRdata = 32'h0080_0000;
        @(negedge clk);
        dmRvalid = 1'b0;
        settle();
        checkOutput("b2b count", 32'(validDataA.size()), 32'd2);
        if (validDataA.size() == 2) begin
            checkOutput("b2b data0", validDataA[0], 32'h0000_00FF);
            checkOutput("b2b data1", validDataA[1], 32'hFFFF_FF80);
        end

        // every op at every byte offset, varied latency, checked by the model
        for (int op = 0; op < 8; op++) begin
            for (int lo = 0; lo < 4; lo++) begin
                applyStimulus(3'(op), 32'h0000_9000 + 32'(lo), 1 + (op + lo) % 3,
                              32'h8765_F0A1 ^ (32'(op) << 29) ^ (32'(lo) << 6), 0);
            end
        end

        settle();
        settle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
